// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package hzd_pkg;

  localparam int REG_ADDR_W_DEF = 4;

  // Memory-wait tracking state.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // Which condition owns the control outputs this cycle, lowest to highest.
  typedef enum logic [1:0] {
    PRIO_NONE   = 2'd0,
    PRIO_HAZARD = 2'd1,
    PRIO_BRANCH = 2'd2,
    PRIO_MEM    = 2'd3
  } prio_e;

  // A memory stall beats a taken branch, which beats a data hazard.
  function automatic prio_e prio_sel(input logic mem_ready, input logic exe_b,
                                     input logic hazard);
    prio_e p;
    if (!mem_ready)  p = PRIO_MEM;
    else if (exe_b)  p = PRIO_BRANCH;
    else if (hazard) p = PRIO_HAZARD;
    else             p = PRIO_NONE;
    return p;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller, bundled for port connection.
interface hazard_ctrl_if
  import hzd_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int STALL_CNT_W = 16,
  parameter int FLUSH_CNT_W = 8
);
  logic                   fwd_en;
  logic [REG_ADDR_W-1:0]  id_src1;
  logic                   id_use_src1;
  logic [REG_ADDR_W-1:0]  id_src2;
  logic                   id_two_src;
  logic [REG_ADDR_W-1:0]  exe_dest;
  logic                   exe_wb_en;
  logic                   exe_mem_r_en;
  logic                   exe_b;
  logic                   mem_ready;
  logic                   freeze_if;
  logic                   flush_if_id;
  logic                   flush_id_ex;
  logic                   freeze_all;
  logic [STALL_CNT_W-1:0] stall_cycles;
  logic [FLUSH_CNT_W-1:0] flush_count;

  // Controller side.
  modport slave (
    input  fwd_en, id_src1, id_use_src1, id_src2, id_two_src,
           exe_dest, exe_wb_en, exe_mem_r_en, exe_b, mem_ready,
    output freeze_if, flush_if_id, flush_id_ex, freeze_all,
           stall_cycles, flush_count
  );

  // Pipeline side.
  modport master (
    output fwd_en, id_src1, id_use_src1, id_src2, id_two_src,
           exe_dest, exe_wb_en, exe_mem_r_en, exe_b, mem_ready,
    input  freeze_if, flush_if_id, flush_id_ex, freeze_all,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (inc_i && (count_q != '1))
      count_d = count_q + 1'b1;
  end

  // Count register, cleared by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and flush controller: Mealy freeze/flush controls for IF/ID and
// ID/EX, global memory-stall freeze, MEM destination shadow and statistics.
module hazard_ctrl
  import hzd_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int STALL_CNT_W = 16,
  parameter int FLUSH_CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);
  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] mem_dest_q;
  logic                  mem_wb_en_q;
  logic                  match_exe, match_mem, hazard;
  prio_e                 prio;
  logic                  freeze_if_w, flush_if_id_w, flush_id_ex_w, freeze_all_w;

  // Source matching and hazard detection; R0 is an ordinary register here.
  always_comb begin
    match_exe = (bus.id_use_src1 && (bus.id_src1 == bus.exe_dest)) ||
                (bus.id_two_src  && (bus.id_src2 == bus.exe_dest));
    match_mem = (bus.id_use_src1 && (bus.id_src1 == mem_dest_q)) ||
                (bus.id_two_src  && (bus.id_src2 == mem_dest_q));
    if (bus.fwd_en)
      hazard = bus.exe_wb_en && bus.exe_mem_r_en && match_exe;
    else
      hazard = (bus.exe_wb_en && match_exe) || (mem_wb_en_q && match_mem);
    prio = prio_sel(bus.mem_ready, bus.exe_b, hazard);
  end

  // Control outputs: same-cycle decode of the winning condition, muted in reset.
  always_comb begin
    freeze_if_w   = 1'b0;
    flush_if_id_w = 1'b0;
    flush_id_ex_w = 1'b0;
    freeze_all_w  = 1'b0;
    if (rst) begin
      case (prio)
        PRIO_MEM:    freeze_all_w = 1'b1;
        PRIO_BRANCH: begin
          flush_if_id_w = 1'b1;
          flush_id_ex_w = 1'b1;
        end
        PRIO_HAZARD: begin
          freeze_if_w   = 1'b1;
          flush_id_ex_w = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Memory-wait state transitions; the exit cycle decodes exactly like RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (!bus.mem_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (bus.mem_ready)  state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // MEM-stage destination shadow; follows ID/EX unless the pipeline is frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_dest_q  <= '0;
      mem_wb_en_q <= 1'b0;
    end else if (!freeze_all_w) begin
      mem_dest_q  <= bus.exe_dest;
      mem_wb_en_q <= bus.exe_wb_en;
    end
  end

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (1'b0),
    .inc_i   (freeze_all_w | freeze_if_w),
    .count_o (bus.stall_cycles)
  );

  sat_counter #(.W(FLUSH_CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (1'b0),
    .inc_i   (flush_if_id_w),
    .count_o (bus.flush_count)
  );

  assign bus.freeze_if   = freeze_if_w;
  assign bus.flush_if_id = flush_if_id_w;
  assign bus.flush_id_ex = flush_id_ex_w;
  assign bus.freeze_all  = freeze_all_w;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  hazard_ctrl_if bus ();

  hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check freeze_if, flush_if_id, flush_id_ex, freeze_all in that order.
  task automatic chk_ctrl(input string tag, input logic fi, input logic fii,
                          input logic fie, input logic fa);
    check_w({tag, ".freeze_if"},   32'(bus.freeze_if),   32'(fi));
    check_w({tag, ".flush_if_id"}, 32'(bus.flush_if_id), 32'(fii));
    check_w({tag, ".flush_id_ex"}, 32'(bus.flush_id_ex), 32'(fie));
    check_w({tag, ".freeze_all"},  32'(bus.freeze_all),  32'(fa));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic fwd);
    bus.fwd_en       = fwd;
    bus.id_src1      = '0;
    bus.id_use_src1  = 1'b0;
    bus.id_src2      = '0;
    bus.id_two_src   = 1'b0;
    bus.exe_dest     = '0;
    bus.exe_wb_en    = 1'b0;
    bus.exe_mem_r_en = 1'b0;
    bus.exe_b        = 1'b0;
    bus.mem_ready    = 1'b1;
  endtask

  task automatic load_use(input logic [3:0] r);
    bus.fwd_en       = 1'b1;
    bus.exe_wb_en    = 1'b1;
    bus.exe_mem_r_en = 1'b1;
    bus.exe_dest     = r;
    bus.id_src1      = r;
    bus.id_use_src1  = 1'b1;
  endtask

  initial begin
    // 1. Reset: outputs forced low even with mem_ready low.
    idle(1'b0);
    bus.mem_ready = 1'b0;
    #2;
    chk_ctrl("in_reset", 0, 0, 0, 0);
    bus.mem_ready = 1'b1;
    #10 rst = 1'b1;
    tick();
    chk_ctrl("idle", 0, 0, 0, 0);
    check_w("idle.stall", 32'(bus.stall_cycles), 0);
    check_w("idle.flush", 32'(bus.flush_count), 0);
    $display("step reset/idle done");

    // 2. Load-use hazard with forwarding.
    load_use(4'd3);
    #1;
    chk_ctrl("load_use", 1, 0, 1, 0);
    tick();
    check_w("load_use.stall", 32'(bus.stall_cycles), 1);
    idle(1'b1);
    #1;
    chk_ctrl("after_load_use", 0, 0, 0, 0);
    tick();
    // Source bit not read: no hazard even though register numbers match.
    load_use(4'd7);
    bus.id_use_src1 = 1'b0;
    #1;
    chk_ctrl("unused_src", 0, 0, 0, 0);
    tick();
    idle(1'b1);
    tick();
    $display("step load-use done");

    // 3. No forwarding: EXE match, then MEM-shadow match.
    idle(1'b0);
    bus.exe_wb_en = 1'b1;
    bus.exe_dest  = 4'd5;
    bus.id_two_src = 1'b1;
    bus.id_src2   = 4'd5;
    #1;
    chk_ctrl("nofwd_exe", 1, 0, 1, 0);
    tick();
    bus.exe_wb_en = 1'b0;
    bus.exe_dest  = 4'd0;
    #1;
    chk_ctrl("nofwd_mem", 1, 0, 1, 0);
    tick();
    check_w("nofwd.stall", 32'(bus.stall_cycles), 3);
    // Same stimulus with forwarding: ALU producers do not stall.
    bus.fwd_en    = 1'b1;
    bus.exe_wb_en = 1'b1;
    bus.exe_dest  = 4'd5;
    #1;
    chk_ctrl("fwd_exe", 0, 0, 0, 0);
    tick();
    bus.exe_wb_en = 1'b0;
    bus.exe_dest  = 4'd0;
    #1;
    chk_ctrl("fwd_mem", 0, 0, 0, 0);
    tick();
    // R0 is a real register.
    idle(1'b0);
    bus.exe_wb_en   = 1'b1;
    bus.exe_dest    = 4'd0;
    bus.id_use_src1 = 1'b1;
    bus.id_src1     = 4'd0;
    #1;
    chk_ctrl("r0_hazard", 1, 0, 1, 0);
    tick();
    check_w("r0.stall", 32'(bus.stall_cycles), 4);
    idle(1'b0);
    tick();
    $display("step no-forwarding done");

    // 4. Taken branch overrides a load-use hazard.
    load_use(4'd3);
    bus.exe_b = 1'b1;
    #1;
    chk_ctrl("branch", 0, 1, 1, 0);
    tick();
    check_w("branch.flush", 32'(bus.flush_count), 1);
    check_w("branch.stall", 32'(bus.stall_cycles), 4);
    idle(1'b1);
    tick();
    $display("step branch done");

    // 5. Memory stall with a pending branch; counters restart from reset.
    rst = 1'b0;
    #1;
    check_w("rst2.stall", 32'(bus.stall_cycles), 0);
    check_w("rst2.flush", 32'(bus.flush_count), 0);
    rst = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    bus.exe_b     = 1'b1;
    bus.exe_dest  = 4'd9;
    bus.exe_wb_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctrl($sformatf("memwait%0d", i), 0, 0, 0, 1);
      tick();
      check_w($sformatf("memwait%0d.mem_dest", i), 32'(dut.mem_dest_q), 0);
      check_w($sformatf("memwait%0d.mem_wb", i), 32'(dut.mem_wb_en_q), 0);
    end
    check_w("memwait.stall", 32'(bus.stall_cycles), 3);
    bus.mem_ready = 1'b1;
    #1;
    chk_ctrl("mem_exit", 0, 1, 1, 0);
    tick();
    check_w("mem_exit.flush", 32'(bus.flush_count), 1);
    check_w("mem_exit.stall", 32'(bus.stall_cycles), 3);
    check_w("mem_exit.mem_dest", 32'(dut.mem_dest_q), 9);
    $display("step mem stall done");

    // Flush counter saturation: 1 + 260 branch cycles.
    idle(1'b1);
    bus.exe_b = 1'b1;
    repeat (260) @(posedge clk);
    #1;
    check_w("flush_sat", 32'(bus.flush_count), 32'h0000_00FF);
    $display("step flush saturation done");

    // 6. Stall counter saturation, then reset mid-stall.
    idle(1'b1);
    load_use(4'd2);
    repeat (65540) @(posedge clk);
    #1;
    check_w("stall_sat", 32'(bus.stall_cycles), 32'h0000_FFFF);
    tick();
    check_w("stall_sat_hold", 32'(bus.stall_cycles), 32'h0000_FFFF);
    chk_ctrl("pre_rst", 1, 0, 1, 0);
    rst = 1'b0;
    #1;
    chk_ctrl("mid_rst", 0, 0, 0, 0);
    check_w("mid_rst.stall", 32'(bus.stall_cycles), 0);
    check_w("mid_rst.flush", 32'(bus.flush_count), 0);
    rst = 1'b1;
    tick();
    chk_ctrl("post_rst", 1, 0, 1, 0);
    check_w("post_rst.stall", 32'(bus.stall_cycles), 1);
    $display("step saturation/reset done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
